// File: rtl/wb_timeout_adapter_if.sv
// wb_if: Wishbone B4 bus bundle shared by the upstream and downstream
// ports of wb_timeout_adapter.
//   master modport : drives request signals, receives DAT_R/TGD_R/ACK/ERR
//   slave modport  : receives request signals, drives DAT_R/TGD_R/ACK/ERR
// Parameters: ADDR_WIDTH, DATA_WIDTH, TAG_WIDTH (TGA/TGD/TGC width).
interface wb_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 4
);
    logic [ADDR_WIDTH-1:0]   ADR;
    logic [TAG_WIDTH-1:0]    TGA;
    logic [2:0]              CTI;
    logic [1:0]              BTE;
    logic [DATA_WIDTH-1:0]   DAT_W;
    logic [TAG_WIDTH-1:0]    TGD_W;
    logic [TAG_WIDTH-1:0]    TGC;
    logic [DATA_WIDTH/8-1:0] SEL;
    logic                    WE;
    logic                    CYC;
    logic                    STB;
    logic [DATA_WIDTH-1:0]   DAT_R;
    logic [TAG_WIDTH-1:0]    TGD_R;
    logic                    ACK;
    logic                    ERR;

    modport master (
        output ADR, TGA, CTI, BTE, DAT_W, TGD_W, TGC, SEL, WE, CYC, STB,
        input  DAT_R, TGD_R, ACK, ERR
    );

    modport slave (
        input  ADR, TGA, CTI, BTE, DAT_W, TGD_W, TGC, SEL, WE, CYC, STB,
        output DAT_R, TGD_R, ACK, ERR
    );
endinterface

// File: rtl/wb_timeout_adapter.sv
// wb_timeout_adapter: Wishbone bus watchdog. Forwards requests unchanged,
// counts how long each strobed access waits for ACK/ERR and, after TIMEOUT
// cycles, aborts the downstream cycle and returns a one-cycle ERR upstream.
// Ports:
//   clk, rstn   : bus clock, asynchronous active-low reset
//   i           : upstream port (wb_if.slave), driven by the master
//   out         : downstream port (wb_if.master), drives the next stage
//   timeout     : one-cycle pulse on every abort
// Optional feature (macro WB_TIMEOUT_ADAPTER_CAPTURE_EN):
//   timeout_cnt : saturating 16-bit abort count
//   timeout_adr : i.ADR captured on entry to ABORT
module wb_timeout_adapter #(
    parameter int unsigned WB_ADDR_WIDTH = 32,
    parameter int unsigned WB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT       = 256
) (
    input  logic                     clk,
    input  logic                     rstn,
    wb_if.slave                      i,
    wb_if.master                     out,
    output logic                     timeout
`ifdef WB_TIMEOUT_ADAPTER_CAPTURE_EN
    ,
    output logic [15:0]              timeout_cnt,
    output logic [WB_ADDR_WIDTH-1:0] timeout_adr
`endif
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ABORT,
        ST_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            fwd;
    logic            resp;

    logic [WB_ADDR_WIDTH-1:0] adr_w;
    logic [WB_DATA_WIDTH-1:0] dat_r_w;

    // Request/data pass-through is purely combinational
    assign adr_w     = i.ADR;
    assign out.ADR   = adr_w;
    assign out.TGA   = i.TGA;
    assign out.CTI   = i.CTI;
    assign out.BTE   = i.BTE;
    assign out.DAT_W = i.DAT_W;
    assign out.TGD_W = i.TGD_W;
    assign out.TGC   = i.TGC;
    assign out.SEL   = i.SEL;
    assign out.WE    = i.WE;
    assign dat_r_w   = out.DAT_R;
    assign i.DAT_R   = dat_r_w;
    assign i.TGD_R   = out.TGD_R;

    // Handshake forwarding only in IDLE/WAIT, and never while in reset
    assign fwd     = rstn && (state_q == ST_IDLE || state_q == ST_WAIT);
    assign resp    = out.ACK | out.ERR;
    assign out.CYC = fwd & i.CYC;
    assign out.STB = fwd & i.STB;
    assign i.ACK   = fwd & out.ACK;
    assign i.ERR   = (fwd & out.ERR) | (rstn && state_q == ST_ABORT);
    assign timeout = rstn && state_q == ST_ABORT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i.CYC && i.STB && !resp) begin
                    state_d = ST_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            ST_WAIT: begin
                if (resp || !i.CYC || !i.STB) begin
                    // Response or master withdrew: next beat re-arms from IDLE
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ABORT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ABORT: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!i.CYC) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef WB_TIMEOUT_ADAPTER_CAPTURE_EN
    logic [15:0]              tcnt_q, tcnt_d;
    logic [WB_ADDR_WIDTH-1:0] tadr_q, tadr_d;

    always_comb begin
        tcnt_d = tcnt_q;
        tadr_d = tadr_q;
        if (state_q == ST_WAIT && state_d == ST_ABORT) begin
            tadr_d = adr_w;
            if (tcnt_q != 16'hFFFF) begin
                tcnt_d = tcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tcnt_q <= '0;
            tadr_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
            tadr_q <= tadr_d;
        end
    end

    assign timeout_cnt = tcnt_q;
    assign timeout_adr = tadr_q;
`endif

endmodule

// File: tb/tb_wb_timeout_adapter.sv
// tb_wb_timeout_adapter: directed scoreboard bench for wb_timeout_adapter
// with TIMEOUT=8. Stimulus pushes expected upstream responses (cycle, ACK,
// ERR, timeout, data) into a queue; a negedge monitor pops and compares on
// every upstream ACK/ERR/timeout.
module tb_wb_timeout_adapter;

    localparam int unsigned TMO = 8;

    logic clk;
    logic rstn;
    logic timeout;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    typedef struct {
        int          cyc;
        bit          ack;
        bit          err;
        bit          tmo;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];

    wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb_m ();
    wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb_s ();

`ifdef WB_TIMEOUT_ADAPTER_CAPTURE_EN
    logic [15:0] timeout_cnt;
    logic [31:0] timeout_adr;
`endif

    wb_timeout_adapter #(
        .WB_ADDR_WIDTH(32),
        .WB_DATA_WIDTH(32),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .i(wb_m),
        .out(wb_s),
        .timeout(timeout)
`ifdef WB_TIMEOUT_ADAPTER_CAPTURE_EN
        ,
        .timeout_cnt(timeout_cnt),
        .timeout_adr(timeout_adr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every upstream response event must match the head of the queue
    always @(negedge clk) begin
        exp_t e;
        if (wb_m.ACK === 1'b1 || wb_m.ERR === 1'b1 || timeout === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {61'd0, wb_m.ACK, wb_m.ERR, timeout}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                chk("resp_ack", {63'd0, wb_m.ACK}, {63'd0, e.ack});
                chk("resp_err", {63'd0, wb_m.ERR}, {63'd0, e.err});
                chk("resp_timeout", {63'd0, timeout}, {63'd0, e.tmo});
                if (e.ack) chk("resp_dat", {32'd0, wb_m.DAT_R}, {32'd0, e.dat});
            end
        end
    end

    // One access (or pipelined burst). ack_at < TMO: slave ACKs k cycles after
    // each beat's c0. Otherwise ERR/timeout expected at c0+TMO; the master then
    // keeps CYC high for hold_cycles more cycles before dropping it.
    task automatic run_access(input logic [31:0] adr, input int nbeats, input int ack_at,
                              input logic [31:0] dat, input int hold_cycles, input bit late_ack);
        int c0;
        exp_t e;
        for (int b = 0; b < nbeats; b++) begin
            for (int k = 0; k <= int'(TMO); k++) begin
                @(posedge clk); #1;
                if (k == 0) begin
                    c0 = cyc;
                    e.cyc = (ack_at < int'(TMO)) ? c0 + ack_at : c0 + int'(TMO);
                    e.ack = (ack_at < int'(TMO));
                    e.err = !(ack_at < int'(TMO));
                    e.tmo = !(ack_at < int'(TMO));
                    e.dat = dat + 32'(b);
                    sb.push_back(e);
                end
                wb_m.CYC   = 1'b1;
                wb_m.STB   = 1'b1;
                wb_m.ADR   = adr + 32'(b * 4);
                wb_s.ACK   = (k == ack_at);
                wb_s.DAT_R = dat + 32'(b);
                @(negedge clk);
                if (k == 0) begin
                    chk("fwd_cyc", {63'd0, wb_s.CYC}, 64'd1);
                    chk("pass_adr", {32'd0, wb_s.ADR}, {32'd0, adr + 32'(b * 4)});
                end
                if (k == int'(TMO)) begin
                    chk("abort_ocyc", {63'd0, wb_s.CYC}, 64'd0);
                    chk("abort_ostb", {63'd0, wb_s.STB}, 64'd0);
                end
                if (k == ack_at && ack_at < int'(TMO)) break;
            end
        end
        if (ack_at >= int'(TMO)) begin
            for (int h = 0; h < hold_cycles; h++) begin
                @(posedge clk); #1;
                wb_s.ACK = late_ack && (h == 1);
                @(negedge clk);
                chk("hold_ocyc", {63'd0, wb_s.CYC}, 64'd0);
                chk("hold_iack", {63'd0, wb_m.ACK}, 64'd0);
            end
        end
        @(posedge clk); #1;
        wb_m.CYC = 1'b0;
        wb_m.STB = 1'b0;
        wb_s.ACK = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rstn        = 1'b0;
        wb_m.CYC    = 1'b1;
        wb_m.STB    = 1'b1;
        wb_m.ADR    = '0;
        wb_m.TGA    = '0;
        wb_m.CTI    = '0;
        wb_m.BTE    = '0;
        wb_m.DAT_W  = 32'h1234_5678;
        wb_m.TGD_W  = '0;
        wb_m.TGC    = '0;
        wb_m.SEL    = '1;
        wb_m.WE     = 1'b0;
        wb_s.DAT_R  = '0;
        wb_s.TGD_R  = '0;
        wb_s.ACK    = 1'b1;
        wb_s.ERR    = 1'b0;

        // Reset state: handshakes gated even with a strobing master
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ocyc", {63'd0, wb_s.CYC}, 64'd0);
        chk("rst_ostb", {63'd0, wb_s.STB}, 64'd0);
        chk("rst_iack", {63'd0, wb_m.ACK}, 64'd0);
        chk("rst_timeout", {63'd0, timeout}, 64'd0);
        chk("rst_dat_w", {32'd0, wb_s.DAT_W}, 64'h1234_5678);
`ifdef WB_TIMEOUT_ADAPTER_CAPTURE_EN
        chk("rst_tcnt", {48'd0, timeout_cnt}, 64'd0);
        chk("rst_tadr", {32'd0, timeout_adr}, 64'd0);
`endif
        @(posedge clk); #1;
        rstn     = 1'b1;
        wb_m.CYC = 1'b0;
        wb_m.STB = 1'b0;
        wb_s.ACK = 1'b0;

        // Single read, ACK at c0+3
        run_access(32'h0000_0100, 1, 3, 32'hCAFE_0001, 0, 1'b0);
        // Silent slave: ERR + timeout at c0+8
        run_access(32'h1000_0040, 1, 99, 32'h0, 0, 1'b0);
`ifdef WB_TIMEOUT_ADAPTER_CAPTURE_EN
        chk("cap_cnt1", {48'd0, timeout_cnt}, 64'd1);
        chk("cap_adr1", {32'd0, timeout_adr}, 64'h1000_0040);
`endif
        // Boundary: ACK at c0+7 completes, ACK at c0+8 loses to the timeout
        run_access(32'h0000_0200, 1, 7, 32'h1111_0007, 0, 1'b0);
        run_access(32'h0000_0300, 1, 8, 32'h2222_0008, 0, 1'b0);
`ifdef WB_TIMEOUT_ADAPTER_CAPTURE_EN
        chk("cap_cnt2", {48'd0, timeout_cnt}, 64'd2);
        chk("cap_adr2", {32'd0, timeout_adr}, 64'h0000_0300);
`endif
        // 4-beat pipelined burst, each beat ACKed after 6 wait cycles
        run_access(32'h0000_0400, 4, 6, 32'hB000_0000, 0, 1'b0);
        // Master holds CYC 5 cycles after ERR with a late ACK, then a normal access
        run_access(32'h0000_0500, 1, 99, 32'h0, 5, 1'b1);
        run_access(32'h0000_0600, 1, 2, 32'h3333_0002, 0, 1'b0);

        // Reset in WAIT at cnt=5, held for 3 cycles
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            wb_m.CYC = 1'b1;
            wb_m.STB = 1'b1;
            wb_m.ADR = 32'h0000_0700;
        end
        for (int r = 0; r < 3; r++) begin
            @(posedge clk); #1;
            rstn     = 1'b0;
            wb_s.ACK = 1'b1;
            @(negedge clk);
            chk("midrst_ocyc", {63'd0, wb_s.CYC}, 64'd0);
            chk("midrst_ostb", {63'd0, wb_s.STB}, 64'd0);
            chk("midrst_iack", {63'd0, wb_m.ACK}, 64'd0);
        end
        @(posedge clk); #1;
        rstn     = 1'b1;
        wb_m.CYC = 1'b0;
        wb_m.STB = 1'b0;
        wb_s.ACK = 1'b0;
        // Full budget after reset: ACK at c0+7 must not see an ERR first
        run_access(32'h0000_0800, 1, 7, 32'h4444_0007, 0, 1'b0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
